// File: rtl/pht_update_scheduler.sv
// Serialises all writes into the gshare PHT: initial sweep, then buffered
// redirect/commit updates applied as read-modify-write pairs on a single-port SRAM.
module pht_update_scheduler #(
  parameter int INDEX_W    = 10,
  parameter int TAG_W      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear_i,
  input  logic                              redir_valid,
  output logic                              redir_ready,
  input  logic [INDEX_W+TAG_W:0]            redir_info,
  input  logic                              cmt_valid,
  output logic                              cmt_ready,
  input  logic [INDEX_W+TAG_W:0]            cmt_info,
  output logic                              pht_en,
  output logic                              pht_we,
  output logic [INDEX_W-1:0]                pht_addr,
  output logic [TAG_W+2:0]                  pht_wdata,
  input  logic [TAG_W+2:0]                  pht_rdata,
  output logic                              init_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int INFO_W = INDEX_W + TAG_W + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    READ,
    WRITE
  } state_t;

  state_t state, state_nx;

  logic [INDEX_W-1:0] sweep_ptr;
  logic [INFO_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               full, empty;
  logic               push, pop;
  logic [INFO_W-1:0]  push_data;
  logic [INFO_W-1:0]  head;
  logic [INDEX_W-1:0] head_idx;
  logic [TAG_W-1:0]   head_tag;
  logic               head_taken;
  logic [2:0]         ctr_cur, ctr_nx;
  logic               unused_rdata_tag;

  assign full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign empty = (fifo_count == '0);

  assign redir_ready = init_done & ~full & ~clear_i;
  assign cmt_ready   = init_done & ~full & ~clear_i & ~redir_valid;

  assign push      = (redir_valid & redir_ready) | (cmt_valid & cmt_ready);
  assign push_data = redir_valid ? redir_info : cmt_info;
  assign pop       = (state == READ) & ~clear_i & ~empty;

  assign head       = mem[rd_ptr];
  assign head_idx   = head[INFO_W-1 -: INDEX_W];
  assign head_tag   = head[TAG_W:1];
  assign head_taken = head[0];

  assign ctr_cur          = pht_rdata[TAG_W+2:TAG_W];
  assign unused_rdata_tag = ^pht_rdata[TAG_W-1:0];

  always_comb begin
    ctr_nx = ctr_cur;
    if (head_taken) begin
      if (ctr_cur != 3'b111) ctr_nx = ctr_cur + 3'd1;
    end else begin
      if (ctr_cur != 3'b000) ctr_nx = ctr_cur - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      sweep_ptr <= '0;
      init_done <= 1'b0;
    end else begin
      state <= state_nx;
      if (clear_i) begin
        sweep_ptr <= '0;
        init_done <= 1'b0;
      end else if (state == INIT) begin
        sweep_ptr <= sweep_ptr + 1'b1;
        if (sweep_ptr == '1) init_done <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      INIT:    if (sweep_ptr == '1) state_nx = IDLE;
      IDLE:    if (!empty) state_nx = READ;
      READ:    state_nx = WRITE;
      WRITE:   state_nx = IDLE;
      default: state_nx = INIT;
    endcase
    if (clear_i) state_nx = INIT;
  end

  // SRAM controls are decoded from state; gating with rst_n keeps them idle
  // while reset is held, and clear_i suppresses the access of its own cycle.
  always_comb begin
    pht_en    = 1'b0;
    pht_we    = 1'b0;
    pht_addr  = '0;
    pht_wdata = '0;
    if (rst_n && !clear_i) begin
      unique case (state)
        INIT: begin
          pht_en    = 1'b1;
          pht_we    = 1'b1;
          pht_addr  = sweep_ptr;
          pht_wdata = {3'b100, {TAG_W{1'b0}}};
        end
        IDLE: begin
          if (!empty) begin
            pht_en   = 1'b1;
            pht_addr = head_idx;
          end
        end
        READ: begin
          pht_en    = 1'b1;
          pht_we    = 1'b1;
          pht_addr  = head_idx;
          pht_wdata = {ctr_nx, head_tag};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (clear_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: doc/pht_update_scheduler.md
Name: pht_update_scheduler

Overview:
- Sequences all writes into the gshare pattern history table (PHT). The PHT is a single-port synchronous SRAM; each entry is {3-bit bimodal counter, TAG_W tag}.
- Accepts update requests from two sources, the commit port and the redirect/mispredict port. Redirect has priority. Requests are buffered in a small FIFO and applied as read-modify-write pairs.
- After reset, or on a clear request, it sweeps the whole table to the initial value before accepting updates.

Parameters:
- INDEX_W, 10, PHT index width; the table has 2**INDEX_W entries.
- TAG_W, 10, tag width per entry.
- FIFO_DEPTH, 4, number of buffered update requests (power of two, ≥2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- clear_i  in  1  synchronous re-initialise request (one-cycle pulse).
- redir_valid  in  1  redirect-port update request.
- redir_ready  out  1  redirect-port accept.
- redir_info  in  INDEX_W+TAG_W+1  {index, tag, taken}.
- cmt_valid  in  1  commit-port update request.
- cmt_ready  out  1  commit-port accept.
- cmt_info  in  INDEX_W+TAG_W+1  {index, tag, taken}.
- pht_en  out  1  SRAM access enable.
- pht_we  out  1  SRAM write enable (valid only with pht_en).
- pht_addr  out  INDEX_W  SRAM address.
- pht_wdata  out  TAG_W+3  {ctr, tag}.
- pht_rdata  in  TAG_W+3  SRAM read data, valid the cycle after a read.
- init_done  out  1  high once the sweep has completed.
- fifo_count  out  clog2(FIFO_DEPTH+1)  current occupancy.

Behaviour:
- Reset values:
  - State = INIT, sweep pointer = 0, FIFO empty.
  - All ready outputs = 0; pht_en = pht_we = 0; pht_addr = 0; pht_wdata = 0.
  - init_done = 0; fifo_count = 0.
- FSM states: INIT, IDLE, READ, WRITE.
- INIT:
  - Each cycle: pht_en = pht_we = 1, pht_addr = pointer, pht_wdata = {3'b100, TAG_W'b0}; pointer then increments.
  - After writing address 2**INDEX_W-1, the next state is IDLE and init_done goes to 1 (registered). The sweep takes exactly 2**INDEX_W cycles.
- Request acceptance:
  - redir_ready = init_done & !full & !clear_i.
  - cmt_ready = init_done & !full & !clear_i & !redir_valid.
  - At most one enqueue per cycle; redirect wins a simultaneous request. A handshake is valid & ready.
- IDLE:
  - If the FIFO is non-empty, issue a read of the head: pht_en = 1, pht_we = 0, pht_addr = head.index. Go to READ.
  - The head is not popped yet.
- READ (the cycle after the read issue; pht_rdata is valid):
  - Compute the new counter c' from c = pht_rdata[TAG_W+2:TAG_W]:
    - c = 3'b111 and taken: c' = 3'b111.
    - c = 3'b000 and not taken: c' = 3'b000.
    - Otherwise c' = c+1 if taken, c-1 if not taken (3-bit saturating).
  - In the same cycle: pht_en = pht_we = 1, pht_addr = head.index, pht_wdata = {c', head.tag}. The tag is always overwritten (replace on miss).
  - Pop the head. Go to WRITE.
- WRITE:
  - One idle bubble cycle, which guarantees a following same-index update reads the new value. Then go to IDLE.
  - Steady-state throughput is one update per 3 cycles.
  - Latency: a request accepted in cycle N (empty FIFO) has its read issued in N+1 and its write in N+2.
- FIFO:
  - Simultaneous enqueue and dequeue is allowed. Occupancy stays unchanged, and a full FIFO cannot enqueue even when popping that cycle (ready uses the registered full).
  - Pointers wrap modulo FIFO_DEPTH.
  - The FIFO is never written while full and never popped while empty.
- clear_i:
  - Honoured in any state. The FIFO is flushed and any in-flight read-modify-write is abandoned: no write is issued in the cycle clear_i is sampled.
  - Pointer = 0, init_done = 0, next state INIT.
  - clear_i during INIT restarts the sweep from 0.
- Asynchronous rst_n assertion mid-operation: all state returns immediately to the reset values above.

Test Plan:
- Reset release: pht_we high for exactly 1024 consecutive cycles with addr 0..1023 and wdata {3'b100, 0}; init_done rises the cycle after addr 1023; no ready asserted before that.
- Single commit {idx=5, tag=0x2A, taken=1} with rdata ctr=3'b110: read addr 5 in N+1; write addr 5, wdata {3'b111, 0x2A} in N+2.
- Saturation: ctr 3'b111 + taken → writes 3'b111; ctr 3'b000 + not-taken → writes 3'b000; ctr 3'b100 + not-taken → writes 3'b011.
- Simultaneous redir_valid and cmt_valid with an empty FIFO: redirect accepted and cmt_ready = 0; commit accepted the next cycle; writes occur in that order.
- Fill the FIFO with 4 requests while the SRAM is busy: both readys go to 0, fifo_count = 4; readys reassert after the first pop; all 4 writes appear in FIFO order.
- clear_i in a READ cycle with 3 entries queued: no write in that cycle, fifo_count becomes 0, a full 1024-cycle sweep restarts at addr 0.
